adcspi_responder: RTL
=====================

# adcspi_responder

SPI target that is the receiving end of the MAX19506 command link: it decodes the 16-bit write frames the ADC SPI master drives on mosi/sclk/cs and holds them in a shadow register file. It runs on the 125 MHz main clock, oversamples the SPI pins, and exposes the shadow registers to the command builder through an 8-bit wishbone responder port. It serves as a loopback checker for ADC configuration traffic and as the ADC register model on the bench.

## Interface
- NUM_REGS, 32, shadow registers (address 0..NUM_REGS-1, max 128)
- clk  in  1  main clock, 125 MHz
- rst_n  in  1  asynchronous, active-low reset
- spi_mosi  in  1  serial data, MSB first, sampled on sclk rising
- spi_sclk  in  1  SPI clock, idle low (mode 0)
- spi_cs  in  1  chip select, active low
- reg_update  out  1  one-cycle pulse per committed SPI write
- reg_update_addr  out  7  address of committed write
- reg_update_data  out  8  data of committed write
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  wishbone strobe/cycle/write
- wb_adr_i  in  16  wishbone address (low 8 bits decoded)
- wb_dat_i  in  8  wishbone write data
- wb_dat_o  out  8  wishbone read data
- wb_ack_o  out  1  wishbone acknowledge

## Operation
- Pins pass through a 2-flop synchronizer, then a registered edge detector (sclk rise, cs fall, cs rise).
- Frame: 16 bits; bit15 R/W (0 = write), bits14:8 address, bits7:0 data.
- FSM states: WAIT_IDLE, IDLE, SHIFT, COMMIT.
  - WAIT_IDLE: entered on reset; moves to IDLE once synced cs is high (a frame in progress at reset release is ignored).
  - IDLE: cs fall -> SHIFT, bit counter = 0, shift register = 0.
  - SHIFT: each sclk rise shifts mosi into LSB; counter saturates at 17. cs rise -> COMMIT.
  - COMMIT (one cycle): counter==16 and bit15==0 and address<NUM_REGS -> write register, pulse reg_update. Counter==16 and bit15==1 -> valid read frame, no write. Otherwise (short, long, or out-of-range address) -> discard, error. Then -> IDLE.
- Wishbone: address 0x00..NUM_REGS-1 reads/writes shadow registers; other addresses read 0x00, writes ignored. Wishbone write in the same cycle as an SPI commit to the same register: SPI value wins; the wishbone access is still acked.
- wb_ack_o: asserted one cycle after stb&cyc with ack low; single-cycle pulse; wb_dat_o valid with ack.
- Reset values: all registers 0x00, reg_update 0, reg_update_addr 0, reg_update_data 0, wb_ack_o 0, wb_dat_o 0x00, FSM WAIT_IDLE.

## Timing
- cs pin rising edge to reg_update: 4 clk cycles (2 sync, 1 edge, 1 commit).
- sclk high and low phases each ≥3 clk cycles; cs high ≥3 clk cycles between frames. The 62.5 MHz-domain master meets this.
- Wishbone read latency: 1 cycle; back-to-back strobes ack every other cycle.
- reg_update_addr/data hold until the next commit.

## Configuration
- ADCSPI_RESP_STATS_EN defined: 8-bit saturating counters at wishbone 0x80 (valid frames, reads included) and 0x81 (error frames); a wishbone write of any value to either clears it. A clear coinciding with an increment clears.
- Not defined: counters absent; 0x80/0x81 read 0x00.

## Structure
- Package adcspi_resp_pkg: frame width (16), field bit positions, FSM state enum, stats addresses 0x80/0x81.
- Sub-module spi_pin_sync: 2-flop synchronizer plus edge detect for sclk/cs/mosi; instantiated once.

## Test plan
- Frame 0x0A5C (write, addr 0x0A, data 0x5C) -> reg_update 4 cycles after cs rise with addr 0x0A, data 0x5C; wishbone read 0x0A returns 0x5C.
- cs raised after 9 bits -> no reg_update, registers unchanged, 0x81 reads 1 (stats on).
- 17 clocked bits, or frame 0x4011 (address 0x40 ≥ NUM_REGS) -> discarded, error counter increments.
- Read frame 0x8A00 -> no write, 0x80 increments, 0x81 unchanged.
- Wishbone write 0x33 to addr 0x05 in the SPI commit cycle of frame 0x0577 -> register 0x05 reads 0x77, both accesses complete.
- rst_n asserted mid-frame and released while cs low -> no commit for that frame; next full frame 0x0101 commits normally.

Source files
------------

// File: rtl/adcspi_resp_pkg.sv
// Shared definitions for the MAX19506 command-link SPI responder.
// Frame layout: bit15 R/W (0 = write), bits14:8 address, bits7:0 data.
// Also holds the FSM state encoding and the statistics register addresses.
package adcspi_resp_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Bit counter: exactly FRAME_BITS marks a well-formed frame, CNT_SAT flags "too long".
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  localparam logic [7:0] STATS_VALID_ADR = 8'h80;
  localparam logic [7:0] STATS_ERR_ADR   = 8'h81;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adcspi_responder_spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and detects edges.
// Latency: 2 cycles of synchronisation; edge pulses appear the cycle after that.
// No backpressure: pins are sampled every cycle.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic cs_o,
  output logic sclk_rise_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_prev_q;
  logic       cs_prev_q;

  // Two-flop synchronisers. cs resets low so a frame already running at
  // reset release is not mistaken for an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      cs_sync_q   <= {cs_sync_q[0], cs_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    end
  end

  // Previous synchronised level, the reference for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  // mosi shares the sclk synchroniser depth, so on an sclk_rise pulse it
  // carries the bit that was on the pin when sclk went high.
  assign mosi_o      = mosi_sync_q[1];
  assign cs_o        = cs_sync_q[1];
  assign sclk_rise_o = sclk_sync_q[1] & ~sclk_prev_q;
  assign cs_fall_o   = ~cs_sync_q[1] & cs_prev_q;
  assign cs_rise_o   = cs_sync_q[1] & ~cs_prev_q;

endmodule

// File: rtl/adcspi_responder.sv
// SPI write-frame decoder with shadow register file and 8-bit wishbone responder.
// Latency: cs pin rise to reg_update 4 cycles; wishbone ack 1 cycle after strobe.
// No SPI backpressure; wishbone acks every other cycle under back-to-back strobes.
// Optional frame statistics at 0x80/0x81 when ADCSPI_RESP_STATS_EN is defined.
module adcspi_responder
  import adcspi_resp_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_mosi,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic        reg_update,
  output logic [6:0]  reg_update_addr,
  output logic [7:0]  reg_update_data,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Synchronised pins and edge pulses
  logic mosi_s, cs_s, sclk_rise, cs_fall, cs_rise;

  spi_pin_sync u_pin_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (spi_sclk),
    .cs_i        (spi_cs),
    .mosi_i      (spi_mosi),
    .mosi_o      (mosi_s),
    .cs_o        (cs_s),
    .sclk_rise_o (sclk_rise),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise)
  );

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        reg_update_q, reg_update_d;
  logic [6:0]  upd_addr_q, upd_addr_d;
  logic [7:0]  upd_data_q, upd_data_d;
  logic        spi_we, frame_valid, frame_err;

  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_addr_ok;

  assign frame_addr    = shift_q[ADDR_MSB:ADDR_LSB];
  assign frame_data    = shift_q[DATA_MSB:DATA_LSB];
  assign frame_addr_ok = (32'(frame_addr) < NUM_REGS);

  // FSM state, bit counter, shift register and commit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      reg_update_q <= 1'b0;
      upd_addr_q   <= '0;
      upd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      reg_update_q <= reg_update_d;
      upd_addr_q   <= upd_addr_d;
      upd_data_q   <= upd_data_d;
    end
  end

  // Frame decode: shift bits while cs is low, classify the frame on cs rise
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    reg_update_d = 1'b0;
    upd_addr_d   = upd_addr_q;
    upd_data_d   = upd_data_q;
    spi_we       = 1'b0;
    frame_valid  = 1'b0;
    frame_err    = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
        if (cs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == FRAME_BITS && !shift_q[RW_BIT] && frame_addr_ok) begin
          spi_we       = 1'b1;
          reg_update_d = 1'b1;
          upd_addr_d   = frame_addr;
          upd_data_d   = frame_data;
          frame_valid  = 1'b1;
        end else if (cnt_q == FRAME_BITS && shift_q[RW_BIT]) begin
          frame_valid  = 1'b1;
        end else begin
          frame_err    = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign reg_update      = reg_update_q;
  assign reg_update_addr = upd_addr_q;
  assign reg_update_data = upd_data_q;

  // Wishbone decode; only the low address byte is significant
  logic             ack_q;
  logic [7:0]       dat_q;
  logic [7:0]       rd_dat;
  logic             wb_req, wb_wr, wb_reg_hit;
  logic [7:0]       wb_adr8;
  logic [IDX_W-1:0] wb_idx, spi_idx;
  logic             unused_adr_hi;

  assign wb_req        = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wb_wr         = wb_req & wb_we_i;
  assign wb_adr8       = wb_adr_i[7:0];
  assign wb_reg_hit    = (32'(wb_adr8) < NUM_REGS);
  assign wb_idx        = wb_adr_i[IDX_W-1:0];
  assign spi_idx       = frame_addr[IDX_W-1:0];
  assign unused_adr_hi = ^wb_adr_i[15:8];

  logic [7:0] regs_q [NUM_REGS];

  // Shadow registers; the SPI write is last so it wins a same-cycle collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      if (wb_wr && wb_reg_hit) regs_q[wb_idx] <= wb_dat_i;
      if (spi_we)              regs_q[spi_idx] <= frame_data;
    end
  end

`ifdef ADCSPI_RESP_STATS_EN
  logic [7:0] valid_cnt_q, err_cnt_q;

  // Saturating frame counters; a wishbone write clears and beats an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_cnt_q <= 8'h00;
      err_cnt_q   <= 8'h00;
    end else begin
      if (wb_wr && wb_adr8 == STATS_VALID_ADR) valid_cnt_q <= 8'h00;
      else if (frame_valid)                    valid_cnt_q <= sat_inc8(valid_cnt_q);
      if (wb_wr && wb_adr8 == STATS_ERR_ADR)   err_cnt_q   <= 8'h00;
      else if (frame_err)                      err_cnt_q   <= sat_inc8(err_cnt_q);
    end
  end
`else
  logic stats_unused;
  assign stats_unused = frame_valid | frame_err;
`endif

  // Read data selection for the addressed location
  always_comb begin
    rd_dat = 8'h00;
    if (wb_reg_hit) begin
      rd_dat = regs_q[wb_idx];
    end
`ifdef ADCSPI_RESP_STATS_EN
    else if (wb_adr8 == STATS_VALID_ADR) begin
      rd_dat = valid_cnt_q;
    end else if (wb_adr8 == STATS_ERR_ADR) begin
      rd_dat = err_cnt_q;
    end
`endif
  end

  // Single-cycle ack one cycle after a fresh strobe; read data captured with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      ack_q <= wb_req;
      if (wb_req && !wb_we_i) dat_q <= rd_dat;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule
